// File: rtl/if_stage_if.sv
// Bundle of the instruction-memory request/ack port and the fetch-to-decode
// valid/ready port of the CPU54 fetch stage.
interface if_stage_if;
    // Instruction memory: a word is returned for im_addr in any cycle where
    // im_req and im_ack are both high; im_ack is meaningless while im_req=0.
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    // Decode handoff: the held instruction transfers on a cycle where
    // ir_valid and id_ready are both high; while ir_valid=1 and id_ready=0
    // ir_out/ir_pc/ir_pc4 stay stable, and ir_valid never drops on its own
    // except through a redirect flush or reset.
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc4;
    logic        ir_valid;
    logic        id_ready;

    modport master (
        output im_req, im_addr, ir_out, ir_pc, ir_pc4, ir_valid,
        input  im_ack, im_rdata, id_ready
    );

    modport slave (
        input  im_req, im_addr, ir_out, ir_pc, ir_pc4, ir_valid,
        output im_ack, im_rdata, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches one word per ack, holds it in
// the instruction register for decode, and flushes on branch/jump redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rstn,
    if_stage_if.master  bus,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        addr_err,
    output logic        dbg_state
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        capture;
    logic        err_next;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc4;
    logic        im_req;

    assign pc_plus4 = pc + 32'd4;

    // A new fetch may go out whenever the IR is empty or is being drained
    // this very cycle, which is what gives one instruction per cycle.
    assign im_req = (state == FETCH) || ((state == VALID) && bus.id_ready);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        err_next   = addr_err;
        if (redirect) begin
            // A redirect wins outright: same-cycle ack data is dropped.
            pc_next    = {redirect_pc[31:2], 2'b00};
            state_next = FETCH;
            if (redirect_pc[1:0] != 2'b00) begin
                err_next = 1'b1;
            end
        end else if (im_req && bus.im_ack) begin
            capture    = 1'b1;
            pc_next    = pc_plus4;
            state_next = VALID;
        end else if ((state == VALID) && bus.id_ready) begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir_out   <= 32'd0;
            ir_pc    <= 32'd0;
            ir_pc4   <= 32'd0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            addr_err <= err_next;
            if (capture) begin
                ir_out <= bus.im_rdata;
                ir_pc  <= pc;
                ir_pc4 <= pc_plus4;
            end
        end
    end

    assign bus.im_req   = im_req;
    assign bus.im_addr  = pc;
    assign bus.ir_out   = ir_out;
    assign bus.ir_pc    = ir_pc;
    assign bus.ir_pc4   = ir_pc4;
    assign bus.ir_valid = (state == VALID);
    assign dbg_state    = state;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// checked against a transaction-level model (PC plus a queue of held fetches).
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        addr_err;
    logic        dbg_state;

    if_stage_if bus();

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .addr_err    (addr_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: fetch address, sticky error, and fetched-but-unconsumed
    // instructions as {pc, word}.
    logic [31:0] m_pc;
    logic        m_err;
    logic [63:0] exp_q[$];

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive(input logic ack, input logic ready, input logic redir,
                         input logic [31:0] rpc, input logic [31:0] rdata);
        @(negedge clk);
        bus.im_ack   = ack;
        bus.id_ready = ready;
        redirect     = redir;
        redirect_pc  = rpc;
        bus.im_rdata = rdata;
        #1;
    endtask

    task automatic advance();
        logic req;
        req = (exp_q.size() == 0) || bus.id_ready;
        if (redirect) begin
            exp_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
        end else begin
            if (exp_q.size() != 0 && bus.id_ready) void'(exp_q.pop_front());
            if (req && bus.im_ack) begin
                exp_q.push_back({m_pc, bus.im_rdata});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.im_ack = 1'b0;
        bus.id_ready = 1'b0;
        redirect = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ir_valid: got %b want 0", bus.ir_valid); end
        tests_run++; if (bus.ir_out !== 32'd0) begin tests_failed++; $display("FAIL reset_ir_out: got %h want 0", bus.ir_out); end
        tests_run++; if (bus.ir_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_ir_pc: got %h want 0", bus.ir_pc); end
        tests_run++; if (bus.ir_pc4 !== 32'd0) begin tests_failed++; $display("FAIL reset_ir_pc4: got %h want 0", bus.ir_pc4); end
        tests_run++; if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        tests_run++; if (bus.im_req !== 1'b1) begin tests_failed++; $display("FAIL reset_im_req: got %b want 1", bus.im_req); end
        tests_run++; if (bus.im_addr !== RESET_PC) begin tests_failed++; $display("FAIL reset_im_addr: got %h want %h", bus.im_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] prev_word;
        prev_word = 32'd0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            w = $urandom;
            drive(1'b1, 1'b1, 1'b0, 32'd0, w);
            tests_run++; if (bus.im_addr !== RESET_PC + 32'(4 * i)) begin tests_failed++; $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.im_addr, RESET_PC + 32'(4 * i)); end
            tests_run++; if (bus.ir_valid !== (i >= 1)) begin tests_failed++; $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.ir_valid, (i >= 1)); end
            if (i >= 1) begin
                tests_run++; if (bus.ir_pc !== RESET_PC + 32'(4 * (i - 1))) begin tests_failed++; $display("FAIL stream_ir_pc[%0d]: got %h want %h", i, bus.ir_pc, RESET_PC + 32'(4 * (i - 1))); end
                tests_run++; if (bus.ir_out !== prev_word) begin tests_failed++; $display("FAIL stream_ir_out[%0d]: got %h want %h", i, bus.ir_out, prev_word); end
            end
            prev_word = w;
            advance();
        end
    endtask

    task automatic test_sparse_ack();
        int captures;
        logic prev_ack;
        logic [31:0] last_word;
        captures = 0;
        prev_ack = 1'b0;
        last_word = 32'd0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic ack;
            logic [31:0] w;
            ack = (i % 3 == 2);
            w = $urandom;
            drive(ack, 1'b1, 1'b0, 32'd0, w);
            tests_run++; if (bus.im_addr !== RESET_PC + 32'(4 * captures)) begin tests_failed++; $display("FAIL sparse_addr[%0d]: got %h want %h", i, bus.im_addr, RESET_PC + 32'(4 * captures)); end
            tests_run++; if (bus.ir_valid !== prev_ack) begin tests_failed++; $display("FAIL sparse_valid[%0d]: got %b want %b", i, bus.ir_valid, prev_ack); end
            if (prev_ack) begin
                tests_run++; if (bus.ir_pc !== RESET_PC + 32'(4 * (captures - 1))) begin tests_failed++; $display("FAIL sparse_ir_pc[%0d]: got %h want %h", i, bus.ir_pc, RESET_PC + 32'(4 * (captures - 1))); end
                tests_run++; if (bus.ir_out !== last_word) begin tests_failed++; $display("FAIL sparse_ir_out[%0d]: got %h want %h", i, bus.ir_out, last_word); end
            end
            if (ack) begin
                captures++;
                last_word = w;
            end
            prev_ack = ack;
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] w2;
        w2 = $urandom;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h8C22_0004);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0, $urandom);
            tests_run++; if (bus.im_req !== 1'b0) begin tests_failed++; $display("FAIL stall_im_req[%0d]: got %b want 0", i, bus.im_req); end
            tests_run++; if (bus.ir_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.ir_valid); end
            tests_run++; if (bus.ir_out !== 32'h8C22_0004) begin tests_failed++; $display("FAIL stall_ir_out[%0d]: got %h want 8c220004", i, bus.ir_out); end
            tests_run++; if (bus.ir_pc !== RESET_PC) begin tests_failed++; $display("FAIL stall_ir_pc[%0d]: got %h want %h", i, bus.ir_pc, RESET_PC); end
            tests_run++; if (bus.im_addr !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.im_addr, RESET_PC + 32'd4); end
            advance();
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0, w2);
        tests_run++; if (bus.im_req !== 1'b1) begin tests_failed++; $display("FAIL resume_im_req: got %b want 1", bus.im_req); end
        tests_run++; if (bus.im_addr !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL resume_addr: got %h want %h", bus.im_addr, RESET_PC + 32'd4); end
        advance();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        tests_run++; if (bus.ir_pc !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL resume_ir_pc: got %h want %h", bus.ir_pc, RESET_PC + 32'd4); end
        tests_run++; if (bus.ir_out !== w2) begin tests_failed++; $display("FAIL resume_ir_out: got %h want %h", bus.ir_out, w2); end
        advance();
    endtask

    task automatic test_redirect();
        logic [31:0] w2;
        w2 = $urandom;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'd0, $urandom);
        advance();
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0100, 32'hDEAD_BEEF);
        advance();
        drive(1'b1, 1'b1, 1'b0, 32'd0, w2);
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush_valid: got %b want 0", bus.ir_valid); end
        tests_run++; if (bus.im_addr !== 32'h0040_0100) begin tests_failed++; $display("FAIL redir_addr: got %h want 00400100", bus.im_addr); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tests_run++; if (bus.ir_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_valid: got %b want 1", bus.ir_valid); end
        tests_run++; if (bus.ir_pc !== 32'h0040_0100) begin tests_failed++; $display("FAIL redir_ir_pc: got %h want 00400100", bus.ir_pc); end
        tests_run++; if (bus.ir_pc4 !== 32'h0040_0104) begin tests_failed++; $display("FAIL redir_ir_pc4: got %h want 00400104", bus.ir_pc4); end
        tests_run++; if (bus.ir_out !== w2) begin tests_failed++; $display("FAIL redir_ir_out: got %h want %h", bus.ir_out, w2); end
        advance();
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0102, 32'd0);
        tests_run++; if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL misal_err_before: got %b want 0", addr_err); end
        advance();
        drive(1'b1, 1'b1, 1'b0, 32'd0, $urandom);
        tests_run++; if (addr_err !== 1'b1) begin tests_failed++; $display("FAIL misal_err_set: got %b want 1", addr_err); end
        tests_run++; if (bus.im_addr !== 32'h0040_0100) begin tests_failed++; $display("FAIL misal_addr: got %h want 00400100", bus.im_addr); end
        advance();
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0200, 32'd0);
        advance();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        tests_run++; if (addr_err !== 1'b1) begin tests_failed++; $display("FAIL misal_err_sticky: got %b want 1", addr_err); end
        tests_run++; if (bus.im_addr !== 32'h0040_0200) begin tests_failed++; $display("FAIL misal_addr2: got %h want 00400200", bus.im_addr); end
        advance();
    endtask

    task automatic test_wrap_and_async_reset();
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = $urandom;
        w1 = $urandom;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd0);
        tests_run++; if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL wrap_err_cleared: got %b want 0", addr_err); end
        advance();
        drive(1'b1, 1'b1, 1'b0, 32'd0, w0);
        tests_run++; if (bus.im_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr0: got %h want fffffffc", bus.im_addr); end
        advance();
        drive(1'b1, 1'b1, 1'b0, 32'd0, w1);
        tests_run++; if (bus.ir_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_ir_pc0: got %h want fffffffc", bus.ir_pc); end
        tests_run++; if (bus.ir_pc4 !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_ir_pc4_0: got %h want 00000000", bus.ir_pc4); end
        tests_run++; if (bus.im_addr !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_addr1: got %h want 00000000", bus.im_addr); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tests_run++; if (bus.ir_pc !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_ir_pc1: got %h want 00000000", bus.ir_pc); end
        tests_run++; if (bus.ir_out !== w1) begin tests_failed++; $display("FAIL wrap_ir_out1: got %h want %h", bus.ir_out, w1); end
        #2;
        rstn = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL async_valid: got %b want 0", bus.ir_valid); end
        tests_run++; if (bus.ir_out !== 32'd0) begin tests_failed++; $display("FAIL async_ir_out: got %h want 0", bus.ir_out); end
        tests_run++; if (bus.ir_pc !== 32'd0) begin tests_failed++; $display("FAIL async_ir_pc: got %h want 0", bus.ir_pc); end
        tests_run++; if (bus.ir_pc4 !== 32'd0) begin tests_failed++; $display("FAIL async_ir_pc4: got %h want 0", bus.ir_pc4); end
        tests_run++; if (bus.im_addr !== RESET_PC) begin tests_failed++; $display("FAIL async_im_addr: got %h want %h", bus.im_addr, RESET_PC); end
        tests_run++; if (bus.im_req !== 1'b1) begin tests_failed++; $display("FAIL async_im_req: got %b want 1", bus.im_req); end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic        ack;
            logic        ready;
            logic        redir;
            logic [31:0] rpc;
            ack   = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom;
            drive(ack, ready, redir, rpc, $urandom);
            tests_run++; if (bus.im_req !== ((exp_q.size() == 0) || ready)) begin tests_failed++; $display("FAIL rand_im_req[%0d]: got %b want %b", i, bus.im_req, ((exp_q.size() == 0) || ready)); end
            tests_run++; if (bus.im_addr !== m_pc) begin tests_failed++; $display("FAIL rand_im_addr[%0d]: got %h want %h", i, bus.im_addr, m_pc); end
            tests_run++; if (bus.ir_valid !== (exp_q.size() != 0)) begin tests_failed++; $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.ir_valid, (exp_q.size() != 0)); end
            tests_run++; if (addr_err !== m_err) begin tests_failed++; $display("FAIL rand_addr_err[%0d]: got %b want %b", i, addr_err, m_err); end
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q[0];
                tests_run++; if (bus.ir_out !== e[31:0]) begin tests_failed++; $display("FAIL rand_ir_out[%0d]: got %h want %h", i, bus.ir_out, e[31:0]); end
                tests_run++; if (bus.ir_pc !== e[63:32]) begin tests_failed++; $display("FAIL rand_ir_pc[%0d]: got %h want %h", i, bus.ir_pc, e[63:32]); end
                tests_run++; if (bus.ir_pc4 !== e[63:32] + 32'd4) begin tests_failed++; $display("FAIL rand_ir_pc4[%0d]: got %h want %h", i, bus.ir_pc4, e[63:32] + 32'd4); end
            end
            advance();
        end
    endtask

    initial begin
        bus.im_ack   = 1'b0;
        bus.im_rdata = 32'd0;
        bus.id_ready = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_sparse_ack();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
